// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, grant and memory signals shared by mem_arbiter and its neighbours
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch (IF) and load/store (D)
// Define ARB_ROUND_ROBIN_EN for alternating arbitration instead of D-priority with starvation guard.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MEM_LAT  = 1,
  parameter int MAX_DPRI = 4
) (
  input logic          clk,
  input logic          nRESET,
  mem_arbiter_if.slave bus
);
  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e        state_q;
  logic [2:0]    lat_q;
  logic          owner_d_q;
  logic          owner_we_q;
  logic          if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
  logic          mem_en_q, mem_we_q, busy_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] MAX_DPRI_C = 4'(MAX_DPRI);
  logic [3:0]    starve_q;
`endif

  logic done_d, issue_d, win_d_d;

  always_comb begin
    done_d  = (state_q == WAIT) && (lat_q == 3'd0);
    issue_d = ((state_q == IDLE) || done_d) && (bus.if_req || bus.d_req);
`ifdef ARB_ROUND_ROBIN_EN
    // owner_d_q doubles as "last granted"; it resets to IF so D wins the first contest
    win_d_d = bus.d_req && (!bus.if_req || !owner_d_q);
`else
    win_d_d = bus.d_req && (!bus.if_req || (starve_q != MAX_DPRI_C));
`endif
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      lat_q       <= 3'd0;
      owner_d_q   <= 1'b0;
      owner_we_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifndef ARB_ROUND_ROBIN_EN
      starve_q    <= 4'd0;
`endif
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if ((state_q == WAIT) && (lat_q != 3'd0)) begin
        lat_q <= lat_q - 3'd1;
      end
      if (done_d) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        if (owner_d_q) begin
          d_rvalid_q <= 1'b1;
          if (!owner_we_q) d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= bus.mem_rdata;
        end
      end
      // a new issue on the completion edge overrides the return to IDLE
      if (issue_d) begin
        state_q   <= WAIT;
        busy_q    <= 1'b1;
        lat_q     <= LAT_C;
        mem_en_q  <= 1'b1;
        owner_d_q <= win_d_d;
        if (win_d_d) begin
          d_gnt_q     <= 1'b1;
          mem_we_q    <= bus.d_we;
          owner_we_q  <= bus.d_we;
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
        end else begin
          if_gnt_q    <= 1'b1;
          owner_we_q  <= 1'b0;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
        end
`ifndef ARB_ROUND_ROBIN_EN
        if (!win_d_d) begin
          starve_q <= 4'd0;
        end else if (bus.if_req && (starve_q != MAX_DPRI_C)) begin
          starve_q <= starve_q + 4'd1;
        end
`endif
      end
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
endmodule
